// File: rtl/alu_pkg.sv
// Shared ALU-side constants: operand/opcode widths, opcode encodings, debounce default.
// Imported by the input-conditioning stage and the ALU so that both agree on encodings.
package alu_pkg;

    localparam int DATA_W              = 4;
    localparam int OP_W                = 4;
    localparam int CAP_CNT_W           = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;   // 10 ms at 50 MHz

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;
    localparam logic [OP_W-1:0] OP_OR  = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR = 4'h4;
    localparam logic [OP_W-1:0] OP_NOT = 4'h5;
    localparam logic [OP_W-1:0] OP_SHL = 4'h6;
    localparam logic [OP_W-1:0] OP_SHR = 4'h7;

endpackage

// File: rtl/operand_capture_debouncer.sv
// One-bit debouncer: 2-flop synchronizer, run-length counter, stable level, rising-edge pulse.
// Latency: stable follows a clean raw change after 2 + DEBOUNCE_CYCLES clocks; no backpressure.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = alu_pkg::DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_pulse_o
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_prev_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // Any clock where the synced level agrees with stable restarts the run,
    // so only an unbroken run of DEBOUNCE_CYCLES differing clocks flips stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (sync_q == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            stable_q <= sync_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable_prev_q <= 1'b0;
        end else begin
            stable_prev_q <= stable_q;
        end
    end

    assign stable_o     = stable_q;
    assign rise_pulse_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/operand_capture.sv
// Conditions board switches and a load button into registered a/b/op for the ALU, live or latched.
// Latency: switch->output 3 clocks, button->load_o 3 + DEBOUNCE_CYCLES clocks; no backpressure.
module operand_capture #(
    parameter int DATA_W          = alu_pkg::DATA_W,
    parameter int OP_W            = alu_pkg::OP_W,
    parameter int DEBOUNCE_CYCLES = alu_pkg::DEBOUNCE_CYCLES_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [DATA_W-1:0]              sw_a_i,
    input  logic [DATA_W-1:0]              sw_b_i,
    input  logic [OP_W-1:0]                sw_op_i,
    input  logic                           mode_i,
    input  logic                           btn_load_i,
    output logic [DATA_W-1:0]              a_o,
    output logic [DATA_W-1:0]              b_o,
    output logic [OP_W-1:0]                op_o,
    output logic                           load_o,
    output logic [alu_pkg::CAP_CNT_W-1:0]  cap_count_o
);
    import alu_pkg::*;

    localparam int SW_W = 2 * DATA_W + OP_W + 1;

    logic [SW_W-1:0]      sw_raw;
    logic [SW_W-1:0]      sw_meta_q;
    logic [SW_W-1:0]      sw_sync_q;
    logic [DATA_W-1:0]    a_sync;
    logic [DATA_W-1:0]    b_sync;
    logic [OP_W-1:0]      op_sync;
    logic                 mode_sync;
    logic                 btn_stable;
    logic                 press;
    logic [CAP_CNT_W-1:0] cap_count_q;

    assign sw_raw = {mode_i, sw_op_i, sw_b_i, sw_a_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_raw;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign {mode_sync, op_sync, b_sync, a_sync} = sw_sync_q;

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_load (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .raw_i        (btn_load_i),
        .stable_o     (btn_stable),
        .rise_pulse_o (press)
    );

    // A press always reloads, so in live mode it is indistinguishable from tracking
    // except for the load pulse and the counter bump.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_o         <= '0;
            b_o         <= '0;
            op_o        <= '0;
            load_o      <= 1'b0;
            cap_count_q <= '0;
        end else begin
            load_o <= press;
            if (press) begin
                cap_count_q <= cap_count_q + CAP_CNT_W'(1);
            end
            if (!mode_sync || press) begin
                a_o  <= a_sync;
                b_o  <= b_sync;
                op_o <= op_sync;
            end
        end
    end

    assign cap_count_o = cap_count_q;

    // The released level is only needed for the edge detect inside the debouncer.
    logic unused_stable;
    assign unused_stable = btn_stable;

endmodule

// File: tb/tb_operand_capture.sv
// Directed bench for operand_capture with a 4-clock debounce window.
module tb_operand_capture;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] sw_a_i, sw_b_i, sw_op_i;
    logic       mode_i, btn_load_i;
    logic [3:0] a_o, b_o, op_o;
    logic       load_o;
    logic [3:0] cap_count_o;

    int n_cmp  = 0;
    int n_err  = 0;
    int pulses = 0;

    operand_capture #(
        .DATA_W          (4),
        .OP_W            (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sw_a_i      (sw_a_i),
        .sw_b_i      (sw_b_i),
        .sw_op_i     (sw_op_i),
        .mode_i      (mode_i),
        .btn_load_i  (btn_load_i),
        .a_o         (a_o),
        .b_o         (b_o),
        .op_o        (op_o),
        .load_o      (load_o),
        .cap_count_o (cap_count_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (load_o === 1'b1) pulses++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i      = 1'b1;
        sw_a_i     = 4'($urandom);
        sw_b_i     = 4'($urandom);
        sw_op_i    = 4'($urandom);
        mode_i     = 1'($urandom);
        btn_load_i = 1'($urandom);
        #2;
        n_cmp++;
        if ({a_o, b_o, op_o, load_o, cap_count_o} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_no_clock: got %h expected 0", {a_o, b_o, op_o, load_o, cap_count_o});
        end
        tick(3);
        n_cmp++;
        if ({a_o, b_o, op_o, load_o, cap_count_o} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_clocked: got %h expected 0", {a_o, b_o, op_o, load_o, cap_count_o});
        end
        sw_a_i = 4'h0; sw_b_i = 4'h0; sw_op_i = 4'h0; mode_i = 1'b0; btn_load_i = 1'b0;
        tick(1);
        rst_i = 1'b0;
        tick(4);
        n_cmp++;
        if ({a_o, b_o, op_o, load_o, cap_count_o} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_after_release: got %h expected 0", {a_o, b_o, op_o, load_o, cap_count_o});
        end
    endtask

    task automatic test_live;
        sw_a_i = 4'h5; sw_b_i = 4'h3; sw_op_i = 4'h2;
        tick(2);
        n_cmp++;
        if (a_o !== 4'h0) begin
            n_err++;
            $display("FAIL live_t2_a: got %h expected 0", a_o);
        end
        tick(1);
        n_cmp++;
        if ({a_o, b_o, op_o} !== 12'h532) begin
            n_err++;
            $display("FAIL live_t3_abop: got %h expected 532", {a_o, b_o, op_o});
        end
        n_cmp++;
        if ({load_o, cap_count_o} !== 5'h0) begin
            n_err++;
            $display("FAIL live_load_cnt: got %h expected 0", {load_o, cap_count_o});
        end
    endtask

    task automatic test_latched;
        mode_i = 1'b1;
        tick(4);
        sw_a_i = 4'hA; sw_b_i = 4'h6; sw_op_i = 4'h1;
        tick(4);
        n_cmp++;
        if ({a_o, b_o, op_o} !== 12'h532) begin
            n_err++;
            $display("FAIL latched_hold: got %h expected 532", {a_o, b_o, op_o});
        end
        btn_load_i = 1'b1;
        tick(6);
        n_cmp++;
        if (load_o !== 1'b0 || a_o !== 4'h5) begin
            n_err++;
            $display("FAIL latched_t6: got load=%b a=%h expected load=0 a=5", load_o, a_o);
        end
        tick(1);
        n_cmp++;
        if ({load_o, a_o, b_o, op_o, cap_count_o} !== {1'b1, 16'hA611}) begin
            n_err++;
            $display("FAIL latched_t7: got %h expected 1a611", {load_o, a_o, b_o, op_o, cap_count_o});
        end
        tick(1);
        n_cmp++;
        if (load_o !== 1'b0) begin
            n_err++;
            $display("FAIL latched_t8_load: got %b expected 0", load_o);
        end
        sw_a_i = 4'hF; sw_b_i = 4'h9; sw_op_i = 4'h7;
        tick(5);
        n_cmp++;
        if ({a_o, b_o, op_o, cap_count_o} !== 16'hA611) begin
            n_err++;
            $display("FAIL latched_sw_change: got %h expected a611", {a_o, b_o, op_o, cap_count_o});
        end
        btn_load_i = 1'b0;
        tick(8);
        n_cmp++;
        if (pulses !== 1 || cap_count_o !== 4'd1) begin
            n_err++;
            $display("FAIL latched_release: got pulses=%0d cnt=%0d expected 1/1", pulses, cap_count_o);
        end
    endtask

    task automatic test_bounce;
        int lv[6] = '{1, 0, 1, 0, 1, 0};
        int rl[6] = '{3, 1, 2, 2, 1, 1};
        int p0;
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            btn_load_i = lv[i][0];
            tick(rl[i]);
        end
        btn_load_i = 1'b0;
        tick(10);
        n_cmp++;
        if (pulses !== p0 || {a_o, b_o, op_o, cap_count_o} !== 16'hA611) begin
            n_err++;
            $display("FAIL bounce_reject: got pulses=%0d state=%h expected %0d/a611", pulses, {a_o, b_o, op_o, cap_count_o}, p0);
        end
        btn_load_i = 1'b1;
        tick(8);
        btn_load_i = 1'b0;
        tick(10);
        n_cmp++;
        if (pulses !== p0 + 1 || {a_o, b_o, op_o, cap_count_o} !== 16'hF972) begin
            n_err++;
            $display("FAIL bounce_clean: got pulses=%0d state=%h expected %0d/f972", pulses, {a_o, b_o, op_o, cap_count_o}, p0 + 1);
        end
    endtask

    task automatic test_wrap_hold;
        logic [3:0] exp_cnt;
        int p0;
        exp_cnt = 4'd2;
        p0 = pulses;
        for (int i = 0; i < 17; i++) begin
            btn_load_i = 1'b1;
            tick(8);
            btn_load_i = 1'b0;
            tick(8);
            exp_cnt = exp_cnt + 4'd1;
            n_cmp++;
            if (cap_count_o !== exp_cnt) begin
                n_err++;
                $display("FAIL wrap_press%0d: got %0d expected %0d", i, cap_count_o, exp_cnt);
            end
        end
        n_cmp++;
        if (pulses !== p0 + 17) begin
            n_err++;
            $display("FAIL wrap_pulses: got %0d expected %0d", pulses - p0, 17);
        end
        p0 = pulses;
        btn_load_i = 1'b1;
        tick(100);
        btn_load_i = 1'b0;
        tick(10);
        n_cmp++;
        if (pulses !== p0 + 1 || cap_count_o !== exp_cnt + 4'd1) begin
            n_err++;
            $display("FAIL hold_single: got pulses=%0d cnt=%0d expected 1/%0d", pulses - p0, cap_count_o, exp_cnt + 4'd1);
        end
    endtask

    task automatic test_reset_mid;
        int p0;
        btn_load_i = 1'b1;
        tick(4);
        #2;
        rst_i = 1'b1;
        p0 = pulses;
        #1;
        n_cmp++;
        if ({a_o, b_o, op_o, load_o, cap_count_o} !== 17'h0) begin
            n_err++;
            $display("FAIL midrst_async: got %h expected 0", {a_o, b_o, op_o, load_o, cap_count_o});
        end
        tick(3);
        rst_i = 1'b0;
        tick(6);
        n_cmp++;
        if (pulses !== p0 || load_o !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_nopulse: got pulses=%0d load=%b expected %0d/0", pulses, load_o, p0);
        end
        tick(1);
        n_cmp++;
        if (load_o !== 1'b1 || cap_count_o !== 4'd1) begin
            n_err++;
            $display("FAIL midrst_pulse: got load=%b cnt=%0d expected 1/1", load_o, cap_count_o);
        end
        tick(1);
        n_cmp++;
        if (load_o !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_pulse_end: got %b expected 0", load_o);
        end
        btn_load_i = 1'b0;
        tick(10);
        n_cmp++;
        if (pulses !== p0 + 1 || cap_count_o !== 4'd1) begin
            n_err++;
            $display("FAIL midrst_final: got pulses=%0d cnt=%0d expected %0d/1", pulses, cap_count_o, p0 + 1);
        end
    endtask

    initial begin
        test_reset;
        test_live;
        test_latched;
        test_bounce;
        test_wrap_hold;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
